// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths and loader state encoding for the single-cycle CPU
//            (PC, instruction memory and boot-time program loader).
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int c_addr_w    = 8;   // instruction byte-address width (8-bit PC)
  localparam int c_data_w    = 32;  // instruction word width
  localparam int c_byte_w    = 8;   // stream byte width
  localparam int c_max_words = 64;  // largest program the loader accepts

  typedef enum logic [2:0] {
    COUNT = 3'd0,
    DATA  = 3'd1,
    WRITE = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_if
// Brief    : Byte-stream valid/ready handshake feeding the program loader.
// Revision : 1.0 - initial release
// ============================================================================
interface prog_loader_if;
  import cpu_pkg::*;

  logic                byte_valid;
  logic [c_byte_w-1:0] byte_data;
  logic                byte_ready;

  // Byte source (e.g. UART RX)
  modport master (output byte_valid, output byte_data, input byte_ready);
  // Loader side
  modport slave  (input byte_valid, input byte_data, output byte_ready);

endinterface
`default_nettype wire

// File: rtl/byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : byte_assembler
// Brief    : Packs four stream bytes little-endian into one instruction word.
//            The word is presented combinationally alongside the 4th byte so
//            the caller can register it on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
module byte_assembler
  import cpu_pkg::*;
#(
  parameter int DATA_W = c_data_w
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                i_clear,
  input  wire logic                i_en,
  input  wire logic [c_byte_w-1:0] i_byte,
  output logic                     o_word_done,
  output logic [DATA_W-1:0]        o_word
);

  // Only the three earlier bytes need storage; the 4th arrives on i_byte.
  logic [1:0]                 r_cnt;
  logic [DATA_W-c_byte_w-1:0] r_shift;

  // New bytes enter at the top and shift down, so byte0 ends up in [7:0].
  assign o_word      = {i_byte, r_shift};
  assign o_word_done = i_en & (r_cnt == 2'd3);

  // Byte counter and shift register; the counter wraps naturally after byte 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 2'd0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_cnt   <= 2'd0;
      r_shift <= '0;
    end else if (i_en) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= o_word[DATA_W-1:c_byte_w];
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Boot-time program loader. Receives a length byte N followed by
//            4*N program bytes, writes each little-endian word to consecutive
//            instruction-memory addresses and holds the CPU in reset until the
//            last word has been written.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = c_addr_w,
  parameter int DATA_W    = c_data_w,
  parameter int MAX_WORDS = c_max_words
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_load_start,
  prog_loader_if.slave     byte_if,
  output logic             o_im_we,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [DATA_W-1:0] o_im_wdata,
  output logic             o_cpu_rst,
  output logic             o_busy,
  output logic             o_err
);

  // Word counters must hold MAX_WORDS itself (the length byte).
  localparam int            c_cnt_w = $clog2(MAX_WORDS + 1);
  localparam logic [c_byte_w-1:0] c_max_n = c_byte_w'(MAX_WORDS);

  loader_state_t      r_state;
  loader_state_t      w_next;
  logic [c_cnt_w-1:0] r_n;
  logic [c_cnt_w-1:0] r_word_idx;
  logic [ADDR_W-1:0]  r_im_addr;
  logic [DATA_W-1:0]  r_im_wdata;
  logic               w_byte_ready;
  logic               w_accept;
  logic               w_word_done;
  logic               w_last_word;
  logic [DATA_W-1:0]  w_word;

  // load_start wins over a simultaneous byte: the byte is simply not taken.
  assign w_accept            = byte_if.byte_valid & w_byte_ready & ~i_load_start;
  assign w_last_word         = (r_word_idx == r_n - c_cnt_w'(1));
  assign byte_if.byte_ready  = w_byte_ready;
  assign o_im_addr           = r_im_addr;
  assign o_im_wdata          = r_im_wdata;

  byte_assembler #(
    .DATA_W (DATA_W)
  ) u_byte_assembler (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (i_load_start),
    .i_en        (w_accept && (r_state == DATA)),
    .i_byte      (byte_if.byte_data),
    .o_word_done (w_word_done),
    .o_word      (w_word)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= COUNT;
    else     r_state <= w_next;
  end

  // Next-state decode and Moore outputs.
  always_comb begin
    w_next       = r_state;
    w_byte_ready = 1'b0;
    o_im_we      = 1'b0;
    o_cpu_rst    = 1'b1;
    o_busy       = 1'b0;
    o_err        = 1'b0;
    case (r_state)
      COUNT: begin
        w_byte_ready = 1'b1;
        o_busy       = 1'b1;
        if (w_accept) begin
          if (byte_if.byte_data == '0)          w_next = RUN;
          else if (byte_if.byte_data > c_max_n) w_next = ERR;
          else                                  w_next = DATA;
        end
      end
      DATA: begin
        w_byte_ready = 1'b1;
        o_busy       = 1'b1;
        if (w_word_done) w_next = WRITE;
      end
      WRITE: begin
        o_im_we = 1'b1;
        o_busy  = 1'b1;
        w_next  = w_last_word ? RUN : DATA;
      end
      RUN: begin
        o_cpu_rst = 1'b0;
      end
      ERR: begin
        o_err = 1'b1;
      end
      default: w_next = COUNT;
    endcase
    if (i_load_start) w_next = COUNT;
  end

  // Length, word index and the registered write address/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n        <= '0;
      r_word_idx <= '0;
      r_im_addr  <= '0;
      r_im_wdata <= '0;
    end else if (i_load_start) begin
      r_n        <= '0;
      r_word_idx <= '0;
    end else begin
      if ((r_state == COUNT) && w_accept && (byte_if.byte_data <= c_max_n))
        r_n <= c_cnt_w'(byte_if.byte_data);
      if (w_word_done) begin
        r_im_wdata <= w_word;
        r_im_addr  <= ADDR_W'({r_word_idx, 2'b00});
      end
      if (r_state == WRITE)
        r_word_idx <= r_word_idx + c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Directed self-checking bench for the boot-time program loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  // Write log filled from the instruction-memory port.
  logic [7:0]  mon_addr [0:63];
  logic [31:0] mon_data [0:63];
  int          wcnt = 0;
  int          base;

  prog_loader_if bus ();

  prog_loader dut (
    .clk          (clk),
    .rst          (rst),
    .i_load_start (load_start),
    .byte_if      (bus),
    .o_im_we      (im_we),
    .o_im_addr    (im_addr),
    .o_im_wdata   (im_wdata),
    .o_cpu_rst    (cpu_rst),
    .o_busy       (busy),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (wcnt < 64) begin
        mon_addr[wcnt] <= im_addr;
        mon_data[wcnt] <= im_wdata;
      end
      wcnt <= wcnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte, hold it until accepted; returns 1ns after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    t = 0;
    while (bus.byte_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("byte_ready_wait", {31'd0, bus.byte_ready}, 32'd1);
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
  endtask

  task automatic pulse_load;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic wait_run;
    int t;
    t = 0;
    while (cpu_rst !== 1'b0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_run", {31'd0, cpu_rst}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},   {31'd0, bus.byte_ready}, 32'd1);
    check({tag, "_we"},      {31'd0, im_we},          32'd0);
    check({tag, "_addr"},    {24'd0, im_addr},        32'd0);
    check({tag, "_wdata"},   im_wdata,                32'd0);
    check({tag, "_cpu_rst"}, {31'd0, cpu_rst},        32'd1);
    check({tag, "_busy"},    {31'd0, busy},           32'd1);
    check({tag, "_err"},     {31'd0, err},            32'd0);
  endtask

  initial begin
    logic [7:0] prog3 [0:11];
    prog3 = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00,
              8'h33, 8'h01, 8'hB5, 8'h00};
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // ---- reset values ----
    #2;
    check_reset_vals("rst");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // ---- test 1: two-word program, back-to-back ----
    send_byte(8'd2, 0);
    check("t1_busy_data", {31'd0, busy}, 32'd1);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
    check("t1_w0_we",    {31'd0, im_we},        32'd1);
    check("t1_w0_addr",  {24'd0, im_addr},      32'h00);
    check("t1_w0_data",  im_wdata,              32'h00500013);
    check("t1_w0_ready", {31'd0, bus.byte_ready}, 32'd0);
    send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'hA0, 0); send_byte(8'h00, 0);
    check("t1_w1_we",      {31'd0, im_we},   32'd1);
    check("t1_w1_addr",    {24'd0, im_addr}, 32'h04);
    check("t1_w1_data",    im_wdata,         32'h00A00093);
    check("t1_w1_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    @(posedge clk); #1;
    check("t1_run_cpu_rst", {31'd0, cpu_rst},        32'd0);
    check("t1_run_we",      {31'd0, im_we},          32'd0);
    check("t1_run_busy",    {31'd0, busy},           32'd0);
    check("t1_run_ready",   {31'd0, bus.byte_ready}, 32'd0);

    // ---- test 2: zero-length program ----
    pulse_load();
    check("t2_count_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("t2_count_busy",    {31'd0, busy},    32'd1);
    base = wcnt;
    send_byte(8'd0, 0);
    check("t2_run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("t2_run_busy",    {31'd0, busy},    32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("t2_no_write", wcnt - base, 32'd0);

    // ---- test 3: over-length program ----
    pulse_load();
    send_byte(8'd65, 0);
    check("t3_err",     {31'd0, err},            32'd1);
    check("t3_cpu_rst", {31'd0, cpu_rst},        32'd1);
    check("t3_ready",   {31'd0, bus.byte_ready}, 32'd0);
    check("t3_busy",    {31'd0, busy},           32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("t3_err_held", {31'd0, err}, 32'd1);
    pulse_load();
    check("t3_clr_err",   {31'd0, err},            32'd0);
    check("t3_clr_busy",  {31'd0, busy},           32'd1);
    check("t3_clr_ready", {31'd0, bus.byte_ready}, 32'd1);

    // ---- test 4: three words with random gaps ----
    base = wcnt;
    send_byte(8'd3, $urandom_range(0, 3));
    for (int i = 0; i < 12; i++) send_byte(prog3[i], $urandom_range(0, 3));
    wait_run();
    check("t4_count", wcnt - base, 32'd3);
    check("t4_a0", {24'd0, mon_addr[base]},   32'h00);
    check("t4_d0", mon_data[base],            32'h00500013);
    check("t4_a1", {24'd0, mon_addr[base+1]}, 32'h04);
    check("t4_d1", mon_data[base+1],          32'h00A00093);
    check("t4_a2", {24'd0, mon_addr[base+2]}, 32'h08);
    check("t4_d2", mon_data[base+2],          32'h00B50133);

    // ---- test 5: abort coinciding with 3rd byte of word 1 ----
    pulse_load();
    send_byte(8'd2, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'h05, 0); send_byte(8'h06, 0);
    bus.byte_valid = 1'b1; bus.byte_data = 8'hEE; load_start = 1'b1;
    @(posedge clk); #1;
    bus.byte_valid = 1'b0; load_start = 1'b0;
    check("t5_abort_we",      {31'd0, im_we},   32'd0);
    check("t5_abort_busy",    {31'd0, busy},    32'd1);
    check("t5_abort_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    base = wcnt;
    send_byte(8'd1, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    check("t5_we",   {31'd0, im_we},   32'd1);
    check("t5_addr", {24'd0, im_addr}, 32'h00);
    check("t5_data", im_wdata,         32'h12345678);
    @(posedge clk); #1;
    check("t5_run",   {31'd0, cpu_rst}, 32'd0);
    check("t5_count", wcnt - base,      32'd1);

    // ---- test 6: asynchronous reset mid-DATA ----
    pulse_load();
    send_byte(8'd2, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("t6_arst");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send_byte(8'd1, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    check("t6_we",   {31'd0, im_we},   32'd1);
    check("t6_addr", {24'd0, im_addr}, 32'h00);
    check("t6_data", im_wdata,         32'hDDCCBBAA);
    @(posedge clk); #1;
    check("t6_run", {31'd0, cpu_rst}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
